// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of the optional per-requester statistics counters.
  localparam int STAT_W = 16;

  // Bits needed to hold values 0..max_value; never narrower than one bit so
  // degenerate configurations (NUM_REQ=1, MAX_BURST=1) still get real vectors.
  function automatic int width_for(input int max_value);
    if (max_value < 2) begin
      return 1;
    end else begin
      return $clog2(max_value + 1);
    end
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority picker: first requester after rr_last (wrapping), with
// rr_last itself searched last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = width_for(NUM_REQ - 1)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic               found,
  output logic [ID_W-1:0]    pick
);

  // Walk the requesters in round-robin order starting just after rr_last.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the async-FIFO write port among NUM_REQ
// requesters. winc/ack/wdata are combinational so that the registered wfull
// flag blocks a write in the very cycle it is high.
// Optional statistics outputs (word_count, stall_count) exist only when the
// macro FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = width_for(NUM_REQ - 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     word_count,
  output logic [STAT_W-1:0]             stall_count
`endif
);

  localparam int              CNT_W    = width_for(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rr_last_q, rr_last_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0]    grant_oh_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  grant_valid_s;
  logic                  req_g_s;
  logic                  accept_s;
  logic                  eob_s;
  logic                  found_s;
  logic [ID_W-1:0]       pick_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .found   (found_s),
    .pick    (pick_s)
  );

  // Decode the grantee into a one-hot mask and select its data word.
  always_comb begin
    grant_oh_s   = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        grant_oh_s[i] = 1'b1;
        grant_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        grant_oh_s[i] = 1'b0;
      end
    end
  end

  assign grant_valid_s = (state_q == BURST);
  assign req_g_s       = |(req & grant_oh_s);
  assign accept_s      = grant_valid_s && req_g_s && !wfull;
  // Burst ends when the grantee lets go or its last allowed word goes out.
  assign eob_s         = !req_g_s || (accept_s && (burst_cnt_q == CNT_LAST));

  assign winc        = accept_s;
  assign ack         = accept_s ? grant_oh_s : '0;
  assign wdata       = grant_valid_s ? grant_data_s : '0;
  assign grant_valid = grant_valid_s;
  assign grant_id    = grant_id_q;

  // Next-state: grant on first request, count words, re-pick at burst end.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d     = BURST;
          grant_id_d  = pick_s;
          rr_last_d   = pick_s;
          burst_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (eob_s) begin
          // rr_last already equals the outgoing grantee, so it is searched last.
          if (found_s) begin
            state_d     = BURST;
            grant_id_d  = pick_s;
            rr_last_d   = pick_s;
            burst_cnt_d = '0;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end else if (accept_s) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state registers; rr_last resets so requester 0 wins first.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_last_q   <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [STAT_W-1:0] word_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;
  logic              stall_s;

  assign stall_s = grant_valid_s && req_g_s && wfull;

  // Saturating per-requester accepted-word counters and stall-cycle counter.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        word_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept_s && grant_oh_s[i] && (word_q[i] != STAT_MAX)) begin
          word_q[i] <= word_q[i] + STAT_W'(1);
        end else begin
          word_q[i] <= word_q[i];
        end
      end
      if (stall_s && (stall_q != STAT_MAX)) begin
        stall_q <= stall_q + STAT_W'(1);
      end else begin
        stall_q <= stall_q;
      end
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    word_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      word_count[i*STAT_W +: STAT_W] = word_q[i];
    end
  end

  assign stall_count = stall_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural round-robin model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          wclk;
  logic          wrst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic          wfull;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          grant_valid;
  logic [1:0]    grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] word_count;
  logic [15:0]     stall_count;
`endif

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .wfull       (wfull),
    .winc        (winc),
    .wdata       (wdata),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_count  (word_count),
    .stall_count (stall_count)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the port, who went last, words served so far.
  bit m_busy;
  int m_owner;
  int m_prev;
  int m_served;
  int m_words [N];
  int m_stalls;

  function automatic int next_in_turn(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      if (r[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_prev   = N - 1;
    m_served = 0;
    for (int i = 0; i < N; i++) m_words[i] = 0;
    m_stalls = 0;
  endtask

  task automatic model_grant(input logic [N-1:0] r);
    int w;
    w = next_in_turn(r, m_prev);
    if (w >= 0) begin
      m_busy = 1'b1; m_owner = w; m_prev = w; m_served = 0;
    end else begin
      m_busy = 1'b0; m_served = 0;
    end
  endtask

  // Apply one clock edge of the arbitration rules to the model.
  task automatic model_step(input logic [N-1:0] r, input logic f);
    bit took;
    took = m_busy && r[m_owner] && !f;
    if (took && m_words[m_owner] < 65535) m_words[m_owner]++;
    if (m_busy && r[m_owner] && f && m_stalls < 65535) m_stalls++;
    if (!m_busy) begin
      model_grant(r);
    end else if (!r[m_owner] || (took && m_served + 1 == MB)) begin
      model_grant(r);
    end else if (took) begin
      m_served++;
    end
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model.
  task automatic cycle(input logic [N-1:0] r, input logic f, input logic rs);
    bit took;
    logic [DW-1:0] exp_data;
    @(negedge wclk);
    req      = r;
    wfull    = f;
    wrst     = rs;
    req_data = $urandom;
    #1;
    if (rs) model_reset();
    took     = m_busy && r[m_owner] && !f;
    exp_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
    check_eq("grant_valid", grant_valid, m_busy);
    if (m_busy) check_eq("grant_id", grant_id, m_owner);
    check_eq("winc", winc, took);
    check_eq("ack", ack, took ? (32'd1 << m_owner) : 32'd0);
    check_eq("wdata", wdata, exp_data);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) check_eq("word_count", word_count[i*16 +: 16], m_words[i]);
    check_eq("stall_count", stall_count, m_stalls);
`endif
    if (!rs) model_step(r, f);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic f;
    logic rs;
    req = '0; req_data = '0; wfull = 1'b0; wrst = 1'b1;
    model_reset();

    // Reset / idle, then requester 0 must win first.
    do_reset();
    check_eq("rst_grant_id", grant_id, 2'd0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check_eq("first_winc_latency", winc, 1'b0);
    // Round-robin: 20 back-to-back words in order 0,1,2,3,0 in bursts of 4.
    for (int k = 0; k < 20; k++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      check_eq("rr_owner", ack, 32'd1 << ((k / 4) % 4));
    end

    // Single requester re-granted continuously.
    do_reset();
    cycle(4'b0100, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      check_eq("single_ack", ack, 4'b0100);
    end

    // Backpressure after word 2 for 5 cycles.
    do_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0001, 1'b1, 1'b0);
      check_eq("bp_winc", winc, 1'b0);
    end
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);

    // Early drop: requester 1 leaves after 2 words, grant returns to 0.
    do_reset();
    cycle(4'b0011, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    check_eq("drop_regrant", ack, 4'b0001);
`ifdef FIFO_ARB_STATS_EN
    check_eq("drop_words1", word_count[16 +: 16], 32'd2);
`endif

    // Reset mid-burst: no write while wrst high, requester 0 first after.
    cycle(4'b0011, 1'b0, 1'b1);
    check_eq("rst_mid_winc", winc, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    check_eq("post_rst_owner", ack, 4'b0001);

    // Random traffic with sticky requests, backpressure and rare resets.
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      end
      f  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(r, f, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
